// File: rtl/tlu_emulator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tlu_emulator_pkg                                                |
// | Purpose  : Shared types and constants for the TLU emulator: handshake      |
// |            state encoding, skipped-counter width and default parameters.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package tlu_emulator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;

  localparam int C_SKIPPED_CNT_W = 16;

  localparam int C_DEF_TRIGGER_NUMBER_BITS = 15;
  localparam int C_DEF_RESET_LENGTH        = 4;
  localparam int C_DEF_BUSY_TIMEOUT        = 65535;

endpackage
`default_nettype wire

// File: rtl/tlu_emulator_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tlu_emulator_sync                                               |
// | Purpose  : Two-flop synchronizer bringing a DUT-side level into CLK.       |
// | Ports    : clk   - destination clock                                       |
// |            rst_n - asynchronous active-low reset (clears both stages)      |
// |            d     - asynchronous input level                                |
// |            q     - synchronized level, two clk cycles behind d             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tlu_emulator_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/tlu_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tlu_emulator                                                    |
// | Purpose  : DUT-side model of an EUDAQ-style Trigger Logic Unit. Issues a   |
// |            trigger on TLU_TRIGGER, waits for TLU_BUSY, then shifts the     |
// |            trigger number out LSB first on rising edges of TLU_CLOCK.      |
// | Ports    : CLK, RST_N        - clock, asynchronous active-low reset        |
// |            ENABLE            - gates acceptance of TRIGGER_REQ             |
// |            TRIGGER_REQ       - one-cycle trigger request                   |
// |            NUMBER_RESET_REQ  - one-cycle number-clear / TLU_RESET request  |
// |            TLU_TRIGGER       - trigger line and serial number data         |
// |            TLU_RESET         - reset pulse to the DUT                      |
// |            TLU_BUSY/CLOCK    - DUT handshake inputs (asynchronous)         |
// |            TRIGGER_NUMBER    - number of the next trigger to issue         |
// |            ACTIVE            - handshake or reset in progress              |
// |            TIMEOUT_ERR       - one-cycle pulse on handshake abort          |
// |            SKIPPED_CNT       - saturating count of rejected requests       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tlu_emulator
  import tlu_emulator_pkg::*;
#(
  parameter int TRIGGER_NUMBER_BITS = C_DEF_TRIGGER_NUMBER_BITS,
  parameter int RESET_LENGTH        = C_DEF_RESET_LENGTH,
  parameter int BUSY_TIMEOUT        = C_DEF_BUSY_TIMEOUT
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           ENABLE,
  input  logic                           TRIGGER_REQ,
  input  logic                           NUMBER_RESET_REQ,
  output logic                           TLU_TRIGGER,
  output logic                           TLU_RESET,
  input  logic                           TLU_BUSY,
  input  logic                           TLU_CLOCK,
  output logic [TRIGGER_NUMBER_BITS-1:0] TRIGGER_NUMBER,
  output logic                           ACTIVE,
  output logic                           TIMEOUT_ERR,
  output logic [C_SKIPPED_CNT_W-1:0]     SKIPPED_CNT
);

  localparam int C_TO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int C_RL_W = (RESET_LENGTH > 1) ? $clog2(RESET_LENGTH) : 1;
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [C_RL_W-1:0] C_RL_LAST = C_RL_W'(RESET_LENGTH - 1);

  logic busy_s;
  logic tclk_s;
  logic tclk_rise;
  logic timed_out;
  logic [TRIGGER_NUMBER_BITS-1:0] num_inc;

  state_e                         state_q,       state_d;
  logic [TRIGGER_NUMBER_BITS-1:0] shreg_q,       shreg_d;
  logic [TRIGGER_NUMBER_BITS-1:0] trig_num_q,    trig_num_d;
  logic [C_TO_W-1:0]              to_cnt_q,      to_cnt_d;
  logic [C_RL_W-1:0]              rl_cnt_q,      rl_cnt_d;
  logic [C_SKIPPED_CNT_W-1:0]     skipped_q,     skipped_d;
  logic                           tlu_trigger_q, tlu_trigger_d;
  logic                           tlu_reset_q,   tlu_reset_d;
  logic                           timeout_err_q, timeout_err_d;
  logic                           active_q,      active_d;
  logic                           tclk_prev_q,   tclk_prev_d;

  tlu_emulator_sync u_sync_busy (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (TLU_BUSY),
    .q     (busy_s)
  );

  tlu_emulator_sync u_sync_tclk (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (TLU_CLOCK),
    .q     (tclk_s)
  );

  assign tclk_prev_d = tclk_s;
  assign tclk_rise   = tclk_s & ~tclk_prev_q;
  // Counter was cleared on entry to WAIT_BUSY, so it holds (cycles spent - 1).
  assign timed_out   = (to_cnt_q == C_TO_LAST);
  assign num_inc     = trig_num_q + TRIGGER_NUMBER_BITS'(1);

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    trig_num_d    = trig_num_q;
    to_cnt_d      = to_cnt_q;
    rl_cnt_d      = rl_cnt_q;
    tlu_trigger_d = tlu_trigger_q;
    tlu_reset_d   = tlu_reset_q;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (NUMBER_RESET_REQ) begin
          state_d     = ST_RESET;
          tlu_reset_d = 1'b1;
          rl_cnt_d    = '0;
          trig_num_d  = '0;
        end else if (TRIGGER_REQ && ENABLE) begin
          state_d       = ST_WAIT_BUSY;
          shreg_d       = trig_num_q;
          tlu_trigger_d = 1'b1;
          to_cnt_d      = '0;
        end
      end

      ST_RESET: begin
        if (rl_cnt_q == C_RL_LAST) begin
          state_d     = ST_IDLE;
          tlu_reset_d = 1'b0;
        end else begin
          rl_cnt_d = rl_cnt_q + C_RL_W'(1);
        end
      end

      ST_WAIT_BUSY: begin
        to_cnt_d = to_cnt_q + C_TO_W'(1);
        if (timed_out) begin
          state_d       = ST_IDLE;
          tlu_trigger_d = 1'b0;
          trig_num_d    = num_inc;
          timeout_err_d = 1'b1;
        end else if (busy_s) begin
          state_d       = ST_SHIFT;
          tlu_trigger_d = 1'b0;
        end
      end

      ST_SHIFT: begin
        to_cnt_d = to_cnt_q + C_TO_W'(1);
        if (timed_out) begin
          state_d       = ST_IDLE;
          tlu_trigger_d = 1'b0;
          trig_num_d    = num_inc;
          timeout_err_d = 1'b1;
        end else if (!busy_s) begin
          state_d       = ST_WAIT_IDLE;
          tlu_trigger_d = 1'b0;
          trig_num_d    = num_inc;
        end else if (tclk_rise) begin
          // Shifting zeros in from the top means clocks beyond the number
          // width naturally present 0 on the line.
          tlu_trigger_d = shreg_q[0];
          shreg_d       = shreg_q >> 1;
        end
      end

      ST_WAIT_IDLE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d       = ST_IDLE;
        tlu_trigger_d = 1'b0;
        tlu_reset_d   = 1'b0;
      end
    endcase
  end

  assign active_d = (state_d != ST_IDLE);

  // A request is rejected when the emulator is busy, or when it collides with
  // a number reset in IDLE (the reset wins). ENABLE plays no part here.
  always_comb begin
    skipped_d = skipped_q;
    if (TRIGGER_REQ && ((state_q != ST_IDLE) || NUMBER_RESET_REQ) &&
        (skipped_q != '1)) begin
      skipped_d = skipped_q + C_SKIPPED_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      trig_num_q    <= '0;
      to_cnt_q      <= '0;
      rl_cnt_q      <= '0;
      skipped_q     <= '0;
      tlu_trigger_q <= 1'b0;
      tlu_reset_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      active_q      <= 1'b0;
      tclk_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      trig_num_q    <= trig_num_d;
      to_cnt_q      <= to_cnt_d;
      rl_cnt_q      <= rl_cnt_d;
      skipped_q     <= skipped_d;
      tlu_trigger_q <= tlu_trigger_d;
      tlu_reset_q   <= tlu_reset_d;
      timeout_err_q <= timeout_err_d;
      active_q      <= active_d;
      tclk_prev_q   <= tclk_prev_d;
    end
  end

  assign TLU_TRIGGER    = tlu_trigger_q;
  assign TLU_RESET      = tlu_reset_q;
  assign TRIGGER_NUMBER = trig_num_q;
  assign ACTIVE         = active_q;
  assign TIMEOUT_ERR    = timeout_err_q;
  assign SKIPPED_CNT    = skipped_q;

endmodule
`default_nettype wire
